// File: rtl/aximm_master_cmd.sv
// AXI4-Lite master: turns one valid/ready register command into one AXI4-Lite write or read,
// with a sticky watchdog flag for slaves that never answer.
module aximm_master_cmd #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // command port
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic                            CMD_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [31:0]                     CMD_WDATA,
  input  logic [3:0]                      CMD_WSTRB,
  // response port
  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic                            RSP_WRITE,
  output logic [31:0]                     RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic                            TIMEOUT,
  // AXI4-Lite write channels
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // AXI4-Lite read channels
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata, StRsp} state_e;

  state_e                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]                     wdata_q;
  logic [3:0]                      wstrb_q;
  logic                            awvalid_q, wvalid_q, arvalid_q;
  logic                            aw_done_q, w_done_q;
  logic                            rsp_write_q;
  logic [31:0]                     rsp_rdata_q;
  logic [1:0]                      rsp_resp_q;
  logic [15:0]                     wdog_q, wdog_d;
  logic                            timeout_q, timeout_d;

  logic cmd_accept, aw_hs, w_hs, aw_done_now, w_done_now, ar_hs, wait_state;

  assign cmd_accept  = (state_q == StIdle) && CMD_VALID;
  assign aw_hs       = awvalid_q && M_AXI_AWREADY;
  assign w_hs        = wvalid_q && M_AXI_WREADY;
  assign aw_done_now = aw_done_q || aw_hs;
  assign w_done_now  = w_done_q || w_hs;
  assign ar_hs       = arvalid_q && M_AXI_ARREADY;
  assign wait_state  = (state_q == StWaddr) || (state_q == StWresp) ||
                       (state_q == StRaddr) || (state_q == StRdata);

  // State register
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (CMD_VALID) state_d = CMD_WRITE ? StWaddr : StRaddr;
      StWaddr: if (aw_done_now && w_done_now) state_d = StWresp;
      StWresp: if (M_AXI_BVALID) state_d = StRsp;
      StRaddr: if (ar_hs) state_d = StRdata;
      StRdata: if (M_AXI_RVALID) state_d = StRsp;
      StRsp:   if (RSP_READY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    CMD_READY     = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_RREADY  = 1'b0;
    RSP_VALID     = 1'b0;
    unique case (state_q)
      StIdle:  CMD_READY    = 1'b1;
      StWresp: M_AXI_BREADY = 1'b1;
      StRdata: M_AXI_RREADY = 1'b1;
      StRsp:   RSP_VALID    = 1'b1;
      default: ;
    endcase
  end

  // Command latch and AXI valid registers
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (cmd_accept) begin
        addr_q    <= CMD_ADDR;
        wdata_q   <= CMD_WDATA;
        wstrb_q   <= CMD_WSTRB;
        awvalid_q <= CMD_WRITE;
        wvalid_q  <= CMD_WRITE;
        arvalid_q <= !CMD_WRITE;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) begin
          awvalid_q <= 1'b0;
          aw_done_q <= 1'b1;
        end
        if (w_hs) begin
          wvalid_q <= 1'b0;
          w_done_q <= 1'b1;
        end
        if (ar_hs) arvalid_q <= 1'b0;
      end
    end
  end

  // Response capture
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else if ((state_q == StWresp) && M_AXI_BVALID) begin
      rsp_write_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= M_AXI_BRESP;
    end else if ((state_q == StRdata) && M_AXI_RVALID) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'(M_AXI_RDATA);
      rsp_resp_q  <= M_AXI_RRESP;
    end
  end

  // Watchdog: counts only while waiting on the slave; the flag is sticky until the next accept.
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (cmd_accept) begin
      wdog_d    = '0;
      timeout_d = 1'b0;
    end else begin
      if (wait_state && (wdog_q != 16'hFFFF)) wdog_d = wdog_q + 16'd1;
      if ((TimeoutLimit != 16'd0) && (wdog_d == TimeoutLimit)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(wdata_q);
  assign M_AXI_WSTRB   = (C_M_AXI_DATA_WIDTH/8)'(wstrb_q);
  assign RSP_WRITE     = rsp_write_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign TIMEOUT       = timeout_q;

endmodule
